uart_rdata_sender: RTL and testbench

UART_RDATA_SENDER -- requirements
Module: uart_rdata_sender

---
 rtl/uart_mon_pkg.sv | 27 ++
 rtl/hex2ascii.sv | 18 +
 rtl/uart_rdata_sender.sv | 119 +++++++++++
 tb/tb_uart_rdata_sender.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// Shared definitions for the UART monitor: sender FSM state encoding,
// ASCII constants and the MSB-first nibble picker.
package uart_mon_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HEX   = 3'd1;
    localparam logic [2:0] ST_SPC   = 3'd2;
    localparam logic [2:0] ST_CR    = 3'd3;
    localparam logic [2:0] ST_LF    = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_LA = 8'h61;

    // Position 0 selects the most significant nibble of the word.
    function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [2:0] pos);
        logic [31:0] shifted;
        shifted = word >> {~pos, 2'b00};
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to ASCII hex digit conversion, upper or lower case.
module hex2ascii
    import uart_mon_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       lower,
    output logic [7:0] char
);

    always_comb begin
        if (nibble < 4'd10) begin
            char = ASC_0 + {4'd0, nibble};
        end else begin
            char = (lower ? ASC_LA : ASC_UA) + {4'd0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_rdata_sender.sv
// Prints one 64-bit dump line or a 32-bit PC line as ASCII hex into the UART
// transmit queue, then waits for the queue to drain before signalling done.
//
// state | meaning
// IDLE  | waiting for rdata_snd_start
// HEX   | emitting hex digit selected by the nibble counter
// SPC   | emitting the space between the two dump words
// CR    | emitting carriage return
// LF    | emitting line feed
// DRAIN | waiting for tx_empty
// DONE  | one-cycle flushing_wq pulse
module uart_rdata_sender
    import uart_mon_pkg::*;
#(
    parameter int HEX_LOWER = 0
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdata_snd_start,
    input  logic [63:0] rdata_snd,
    input  logic        pc_print_sel,
    input  logic        tx_full,
    input  logic        tx_empty,
    output logic [7:0]  tx_wdata,
    output logic        tx_we,
    output logic        flushing_wq,
    output logic        snd_busy
);

    logic [2:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [63:0] data_q;
    logic        pc_q;
    logic [3:0]  nibble;
    logic [7:0]  hex_char;
    logic [7:0]  char_cur;
    logic        emitting;

    // Counter values 8..15 walk the upper word of a dump line.
    assign nibble = nibble_at(cnt[3] ? data_q[63:32] : data_q[31:0], cnt[2:0]);

    hex2ascii u_hex2ascii (
        .nibble (nibble),
        .lower  (HEX_LOWER != 0),
        .char   (hex_char)
    );

    always_comb begin
        char_cur = 8'h00;
        case (state)
            ST_HEX:  char_cur = hex_char;
            ST_SPC:  char_cur = ASC_SP;
            ST_CR:   char_cur = ASC_CR;
            ST_LF:   char_cur = ASC_LF;
            default: char_cur = 8'h00;
        endcase
    end

    assign emitting    = (state == ST_HEX) || (state == ST_SPC) ||
                         (state == ST_CR)  || (state == ST_LF);
    assign tx_we       = emitting && !tx_full;
    assign tx_wdata    = tx_we ? char_cur : 8'h00;
    assign flushing_wq = (state == ST_DONE);
    assign snd_busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (rdata_snd_start) begin
                    state_nxt = ST_HEX;
                    cnt_nxt   = 4'd0;
                end
            end
            ST_HEX: begin
                if (!tx_full) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state_nxt = ST_CR;
                    end else if (cnt == 4'd7) begin
                        state_nxt = pc_q ? ST_CR : ST_SPC;
                    end
                end
            end
            ST_SPC: begin
                if (!tx_full) state_nxt = ST_HEX;
            end
            ST_CR: begin
                if (!tx_full) state_nxt = ST_LF;
            end
            ST_LF: begin
                if (!tx_full) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tx_empty) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            data_q <= 64'd0;
            pc_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if ((state == ST_IDLE) && rdata_snd_start) begin
                data_q <= rdata_snd;
                pc_q   <= pc_print_sel;
            end
        end
    end

endmodule

// File: tb/tb_uart_rdata_sender.sv
// Self-checking bench for uart_rdata_sender: upper- and lower-case instances
// share stimulus; expected lines come from formatted strings.
module tb_uart_rdata_sender;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] rdata = 64'd0;
    logic        pc_sel = 1'b0;
    logic        tx_full = 1'b0;
    logic        tx_empty = 1'b1;
    logic [7:0]  wdata_up, wdata_lo;
    logic        we_up, we_lo, flush_up, flush_lo, busy_up, busy_lo;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    uart_rdata_sender #(.HEX_LOWER(0)) u_up (
        .clk(clk), .rst_n(rst_n), .rdata_snd_start(start), .rdata_snd(rdata),
        .pc_print_sel(pc_sel), .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_wdata(wdata_up), .tx_we(we_up), .flushing_wq(flush_up), .snd_busy(busy_up)
    );

    uart_rdata_sender #(.HEX_LOWER(1)) u_lo (
        .clk(clk), .rst_n(rst_n), .rdata_snd_start(start), .rdata_snd(rdata),
        .pc_print_sel(pc_sel), .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_wdata(wdata_lo), .tx_we(we_lo), .flushing_wq(flush_lo), .snd_busy(busy_lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected characters of one line, built from a printf-style string.
    function automatic bq_t build(input logic [63:0] d, input bit pc, input bit lower);
        string      s;
        bq_t        q;
        logic [7:0] c;
        if (pc) s = $sformatf("%08h", d[31:0]);
        else    s = $sformatf("%08h %08h", d[31:0], d[63:32]);
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (!lower && c >= 8'h61 && c <= 8'h66) c = c - 8'h20;
            q.push_back(c);
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, {we_lo, we_up}, 2'b00);
        chk({tag, "_wdata"}, {wdata_lo, wdata_up}, 16'h0000);
        chk({tag, "_flush"}, {flush_lo, flush_up}, 2'b00);
        chk({tag, "_busy"}, {busy_lo, busy_up}, 2'b00);
    endtask

    task automatic run_line(input logic [63:0] d, input bit pc, input int stall_after,
                            input int stall_len, input int drain_low, input bit dup_start,
                            input int rst_after);
        bq_t eu, el;
        int  nchar = 0;
        int  stall_left = 0;
        int  drain_left = drain_low;
        int  flush_cyc = -1;
        int  lf_cyc = -1;
        int  cyc = 0;
        bit  done = 0;
        bit  dup_sent = 0;
        eu = build(d, pc, 1'b0);
        el = build(d, pc, 1'b1);

        @(negedge clk);
        start = 1'b1; rdata = d; pc_sel = pc; tx_full = 1'b0; tx_empty = 1'b1;
        #1;
        chk("start_busy", busy_up, 1'b0);
        chk("start_we", we_up, 1'b0);

        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (dup_start && !dup_sent && nchar == 4) begin
                start = 1'b1;
                dup_sent = 1'b1;
            end
            rdata    = {$urandom, $urandom};
            pc_sel   = 1'($urandom);
            tx_full  = (stall_left > 0);
            tx_empty = !(lf_cyc >= 0 && drain_left > 0);
            if (rst_after > 0 && nchar == rst_after) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("rst_now");
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    chk_all_zero("rst_hold");
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            #1;
            if (tx_full) begin
                chk("stall_we", {we_lo, we_up}, 2'b00);
                chk("stall_wdata", {wdata_lo, wdata_up}, 16'h0000);
                stall_left--;
            end else begin
                chk("we_up", we_up, nchar < eu.size());
                chk("we_lo", we_lo, nchar < el.size());
            end
            if (we_up && nchar < eu.size()) begin
                chk("char_up", wdata_up, eu[nchar]);
                chk("char_lo", wdata_lo, el[nchar]);
                nchar++;
                if (nchar == stall_after) stall_left = stall_len;
                if (nchar == eu.size()) lf_cyc = cyc;
            end else begin
                chk("wdata_zero", wdata_up, 8'h00);
            end
            if (lf_cyc >= 0 && cyc > lf_cyc) begin
                if (!tx_empty) drain_left--;
                else if (flush_cyc < 0) flush_cyc = cyc + 1;
            end
            chk("flush_up", flush_up, cyc == flush_cyc);
            chk("flush_lo", flush_lo, cyc == flush_cyc);
            chk("busy", busy_up, 1'b1);
            if (cyc == flush_cyc) done = 1'b1;
        end
        chk("timeout", done, 1'b1);
        chk("char_count", nchar, eu.size());

        @(negedge clk);
        tx_full = 1'b0; tx_empty = 1'b1; start = 1'b0;
        #1;
        chk("post_busy", busy_up, 1'b0);
        chk("post_flush", flush_up, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_line(64'h89ABCDEF_01234567, 1'b0, 0, 0, 0, 1'b0, 0);
        run_line({32'hDEADBEEF, 32'h00001A2C}, 1'b1, 0, 0, 0, 1'b0, 0);
        run_line({$urandom, $urandom}, 1'b0, 3, 5, 0, 1'b0, 0);
        run_line({$urandom, $urandom}, 1'b1, 0, 0, 10, 1'b0, 0);
        run_line({$urandom, $urandom}, 1'b0, 0, 0, 0, 1'b1, 0);
        run_line({$urandom, $urandom}, 1'b0, 0, 0, 0, 1'b0, 6);
        run_line({$urandom, $urandom}, 1'b0, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            run_line({$urandom, $urandom}, 1'($urandom), $urandom_range(1, 18),
                     $urandom_range(0, 4), $urandom_range(0, 5), 1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
